// File: rtl/mux_scan_pkg.sv
// Shared types and limits for the mux channel scanner and its sequencer.
package mux_scan_pkg;

  localparam int NCH        = 4;
  localparam int SELW       = $clog2(NCH);
  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;
  localparam int CNTW       = $clog2(SETTLE_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } scan_state_t;

  // Out-of-range settle values are pinned to the nearest legal bound.
  function automatic int clamp_settle(input int v);
    if (v < SETTLE_MIN) return SETTLE_MIN;
    if (v > SETTLE_MAX) return SETTLE_MAX;
    return v;
  endfunction

endpackage

// File: rtl/scan_sequencer.sv
// Scan FSM, mux select and settle counter for the mux channel scanner.
//   state  | meaning
//   IDLE   | waiting for start
//   SETTLE | select stable, waiting SETTLE cycles for the mux output
//   SAMPLE | capture m into slot s, then advance or finish
//   HOLD   | full frame presented, waiting for acceptance
module scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic            cont,
  input  logic            accept,
  output scan_state_t     state,
  output logic [SELW-1:0] s,
  output logic            sample,
  output logic            sample_last
);

  localparam int SETTLE_C = clamp_settle(SETTLE);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(SETTLE_C - 1);
  localparam logic [SELW-1:0] S_LAST   = SELW'(NCH - 1);

  scan_state_t     state_q, state_d;
  logic [SELW-1:0] s_q, s_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    cnt_d       = cnt_q;
    sample      = 1'b0;
    sample_last = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETTLE;
          s_d     = '0;
          cnt_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        sample = 1'b1;
        if (s_q == S_LAST) begin
          sample_last = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          s_d     = s_q + 1'b1;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_HOLD: begin
        // s stays at the last channel until a new scan begins
        if (accept) begin
          if (cont) begin
            state_d = ST_SETTLE;
            s_d     = '0;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign state = state_q;
  assign s     = s_q;

endmodule

// File: rtl/mux_channel_scanner.sv
// Scans a 4-to-1 mux, assembles {ch3,ch2,ch1,ch0} and hands the frame off via valid/ready.
// Optional frame parity output is enabled by defining SCANNER_PARITY_EN.
module mux_channel_scanner
  import mux_scan_pkg::*;
#(
  parameter int DWIDTH = 2,
  parameter int SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  cont,
  output logic [SELW-1:0]       s,
  input  logic [DWIDTH-1:0]     m,
  output logic [NCH*DWIDTH-1:0] frame_data,
  output logic                  frame_valid,
  input  logic                  frame_ready,
`ifdef SCANNER_PARITY_EN
  output logic                  frame_par,
`endif
  output logic                  busy
);

  scan_state_t           state;
  logic                  sample;
  logic                  sample_last;
  logic                  accept;
  logic [NCH*DWIDTH-1:0] frame_d;

  assign accept = frame_valid & frame_ready;

  scan_sequencer #(
    .SETTLE(SETTLE)
  ) u_seq (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .cont       (cont),
    .accept     (accept),
    .state      (state),
    .s          (s),
    .sample     (sample),
    .sample_last(sample_last)
  );

  // Slots update in place; the rest of the frame keeps its previous contents.
  always_comb begin
    frame_d = frame_data;
    if (sample) frame_d[int'(s)*DWIDTH +: DWIDTH] = m;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_data  <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_data <= frame_d;
      if (sample_last)  frame_valid <= 1'b1;
      else if (accept)  frame_valid <= 1'b0;
    end
  end

`ifdef SCANNER_PARITY_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) frame_par <= 1'b0;
    else         frame_par <= ^frame_d;
  end
`endif

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Self-checking bench: three scanners (SETTLE 2, 1, 15) behind behavioural 4-to-1 muxes.
module tb_mux_channel_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn, start, cont, frame_ready;
  logic [1:0] ch [4];

  logic [1:0] s2, s1, s15, m2, m1, m15;
  logic [7:0] fd2, fd1, fd15;
  logic       fv2, fv1, fv15, busy2, busy1, busy15;
`ifdef SCANNER_PARITY_EN
  logic       par2, par1, par15;
`endif

  assign m2  = ch[s2];
  assign m1  = ch[s1];
  assign m15 = ch[s15];

  int checks   = 0;
  int failures = 0;

  mux_channel_scanner #(.DWIDTH(2), .SETTLE(2)) dut2 (
    .clk(clk), .resetn(resetn), .start(start), .cont(cont), .s(s2), .m(m2),
    .frame_data(fd2), .frame_valid(fv2), .frame_ready(frame_ready),
`ifdef SCANNER_PARITY_EN
    .frame_par(par2),
`endif
    .busy(busy2));

  mux_channel_scanner #(.DWIDTH(2), .SETTLE(1)) dut1 (
    .clk(clk), .resetn(resetn), .start(start), .cont(cont), .s(s1), .m(m1),
    .frame_data(fd1), .frame_valid(fv1), .frame_ready(frame_ready),
`ifdef SCANNER_PARITY_EN
    .frame_par(par1),
`endif
    .busy(busy1));

  mux_channel_scanner #(.DWIDTH(2), .SETTLE(15)) dut15 (
    .clk(clk), .resetn(resetn), .start(start), .cont(cont), .s(s15), .m(m15),
    .frame_data(fd15), .frame_valid(fv15), .frame_ready(frame_ready),
`ifdef SCANNER_PARITY_EN
    .frame_par(par15),
`endif
    .busy(busy15));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_ch();
    for (int i = 0; i < 4; i++) ch[i] = 2'($urandom_range(0, 3));
  endtask

  function automatic logic [7:0] model_frame();
    return {ch[3], ch[2], ch[1], ch[0]};
  endfunction

  // One-shot scan on all three instances; latency is counted in edges after the start edge.
  task automatic scan_all(input string tag);
    int         l2 = 0, l1 = 0, l15 = 0;
    logic [7:0] e, d2 = '0, d1 = '0, d15 = '0;
    int         exp_s;
`ifdef SCANNER_PARITY_EN
    logic       p2 = 1'b0, p1 = 1'b0, p15 = 1'b0;
`endif
    e           = model_frame();
    frame_ready = 1'b1;
    cont        = 1'b0;
    start       = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 70; n++) begin
      tick();
      if (n <= 12) begin
        exp_s = (n / 3 > 3) ? 3 : n / 3;
        chk({tag, "_s_seq"}, 32'(s2), 32'(exp_s));
        chk({tag, "_busy"}, 32'(busy2), 32'd1);
      end
      if (fv2 && l2 == 0) begin
        l2 = n; d2 = fd2;
`ifdef SCANNER_PARITY_EN
        p2 = par2;
`endif
      end
      if (fv1 && l1 == 0) begin
        l1 = n; d1 = fd1;
`ifdef SCANNER_PARITY_EN
        p1 = par1;
`endif
      end
      if (fv15 && l15 == 0) begin
        l15 = n; d15 = fd15;
`ifdef SCANNER_PARITY_EN
        p15 = par15;
`endif
      end
    end
    chk({tag, "_lat_settle2"}, 32'(l2), 32'd12);
    chk({tag, "_lat_settle1"}, 32'(l1), 32'd8);
    chk({tag, "_lat_settle15"}, 32'(l15), 32'd64);
    chk({tag, "_data_settle2"}, 32'(d2), 32'(e));
    chk({tag, "_data_settle1"}, 32'(d1), 32'(e));
    chk({tag, "_data_settle15"}, 32'(d15), 32'(e));
`ifdef SCANNER_PARITY_EN
    chk({tag, "_par_settle2"}, 32'(p2), 32'(^e));
    chk({tag, "_par_settle1"}, 32'(p1), 32'(^e));
    chk({tag, "_par_settle15"}, 32'(p15), 32'(^e));
`endif
    chk({tag, "_idle_after"}, 32'(busy2), 32'd0);
  endtask

  initial begin
    int         n, nf, last;
    logic [7:0] e;

    // reset state
    resetn = 1'b0; start = 1'b0; cont = 1'b0; frame_ready = 1'b0;
    for (int i = 0; i < 4; i++) ch[i] = 2'd0;
    tick(); tick();
    chk("rst_s", 32'(s2), 32'd0);
    chk("rst_data", 32'(fd2), 32'd0);
    chk("rst_valid", 32'(fv2), 32'd0);
    chk("rst_busy", 32'(busy2), 32'd0);
    resetn = 1'b1;
    tick();

    // directed frame u=01 v=00 w=11 x=10 -> 8'hB1
    ch[0] = 2'b01; ch[1] = 2'b00; ch[2] = 2'b11; ch[3] = 2'b10;
    chk("model_b1", 32'(model_frame()), 32'hB1);
    scan_all("basic");
    repeat (2) begin
      new_ch();
      scan_all("rand");
    end

    // directed frame 8'h04, then hold with frame_ready low and stray starts
    ch[0] = 2'b00; ch[1] = 2'b01; ch[2] = 2'b00; ch[3] = 2'b00;
    frame_ready = 1'b0; cont = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    chk("hold_not_yet", 32'(fv2), 32'd0);
    tick();
    chk("hold_valid", 32'(fv2), 32'd1);
    chk("hold_data04", 32'(fd2), 32'h04);
`ifdef SCANNER_PARITY_EN
    chk("hold_par", 32'(par2), 32'd1);
`endif
    for (int i = 0; i < 20; i++) begin
      start = 1'($urandom_range(0, 1));
      new_ch();
      tick();
      chk("hold_valid_stable", 32'(fv2), 32'd1);
      chk("hold_data_stable", 32'(fd2), 32'h04);
      chk("hold_s3", 32'(s2), 32'd3);
      chk("hold_busy", 32'(busy2), 32'd1);
    end
    frame_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("accept_clears_valid", 32'(fv2), 32'd0);
    chk("accept_start_ignored", 32'(busy2), 32'd0);
    tick();
    chk("accept_stays_idle", 32'(busy2), 32'd0);

    // continuous mode, randomised frames back to back
    new_ch();
    e = model_frame();
    cont = 1'b1; frame_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0; nf = 0; last = 0;
    while (nf < 6 && n < 200) begin
      tick();
      n++;
      chk("cont_busy", 32'(busy2), 32'd1);
      if (fv2) begin
        nf++;
        chk("cont_data", 32'(fd2), 32'(e));
        chk("cont_period", 32'(n - last), (nf == 1) ? 32'd12 : 32'd13);
        last = n;
        if (nf == 6) cont = 1'b0;
        else begin
          new_ch();
          e = model_frame();
        end
      end
    end
    chk("cont_frames", 32'(nf), 32'd6);
    tick();
    chk("cont_stop_idle", 32'(busy2), 32'd0);
    chk("cont_stop_valid", 32'(fv2), 32'd0);

    // reset during SETTLE of channel 2
    new_ch();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("pre_rst_s", 32'(s2), 32'd2);
    chk("pre_rst_busy", 32'(busy2), 32'd1);
    resetn = 1'b0;
    #1;
    chk("midrst_s", 32'(s2), 32'd0);
    chk("midrst_data", 32'(fd2), 32'd0);
    chk("midrst_valid", 32'(fv2), 32'd0);
    chk("midrst_busy", 32'(busy2), 32'd0);
    chk("midrst_busy15", 32'(busy15), 32'd0);
`ifdef SCANNER_PARITY_EN
    chk("midrst_par", 32'(par2), 32'd0);
`endif
    tick(); tick();
    resetn = 1'b1;
    new_ch();
    scan_all("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_channel_scanner.md
MUX_CHANNEL_SCANNER -- requirements
Module: mux_channel_scanner

Interface
REQ-001 SHALL have parameter DWIDTH, default 2, meaning width of each mux data channel.
REQ-002 SHALL have parameter SETTLE, default 2, legal range 1..15, meaning clock cycles between a select change and its sample.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a scan; honoured only in IDLE.
REQ-006 SHALL have port cont  input  1  continuous mode; sampled when a frame is accepted.
REQ-007 SHALL have port s  output  2  select driven to the downstream 4-to-1 mux.
REQ-008 SHALL have port m  input  DWIDTH  selected data returned from the mux.
REQ-009 SHALL have port frame_data  output  4*DWIDTH  captured frame {ch3,ch2,ch1,ch0}.
REQ-010 SHALL have port frame_valid  output  1  frame_data holds a complete, unaccepted frame.
REQ-011 SHALL have port frame_ready  input  1  consumer accepts frame when high with frame_valid.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement the FSM states IDLE, SETTLE, SAMPLE, and HOLD.
REQ-014 SHALL, in IDLE with start=1, clear s to 0 and the settle counter to 0, then move to SETTLE.
REQ-015 SHALL stay in SETTLE exactly SETTLE cycles, then move to SAMPLE.
REQ-016 SHALL, in SAMPLE, write m into slot s of the frame register.
REQ-017 SHALL, in SAMPLE with s<3, increment s and return to SETTLE; with s=3, move to HOLD and set frame_valid.
REQ-018 SHALL assert frame_valid exactly 4*(SETTLE+1) cycles after the edge that accepts start (12 at default).
REQ-019 SHALL hold frame_data and frame_valid stable in HOLD until frame_valid and frame_ready are high on the same edge.
REQ-020 SHALL, on acceptance, clear frame_valid in the same edge; cont=1 restarts at s=0 in SETTLE, cont=0 returns to IDLE.
REQ-021 SHALL ignore start outside IDLE, including start coincident with acceptance.
REQ-022 SHALL keep s constant across every SETTLE and SAMPLE cycle of one channel.
REQ-023 SHALL leave s at 3 in HOLD, with no wrap until a restart.
REQ-024 SHALL leave frame_data unchanged except in SAMPLE, so each slot updates in place during a scan.

Reset
REQ-025 SHALL, on resetn low at any time including mid-scan or HOLD, force IDLE, s=0, frame_data=0, frame_valid=0, busy=0, and counter=0 immediately.
REQ-026 SHALL discard any partial frame on reset.
REQ-027 SHALL ignore start on the first edge after reset release unless resetn is high before that edge.

Configuration
REQ-028 SHALL, with macro SCANNER_PARITY_EN defined, add output frame_par (1 bit) equal to the XOR of all frame_data bits, registered with and stable alongside frame_data, reset 0.
REQ-029 SHALL, without SCANNER_PARITY_EN, have no frame_par port and no parity logic.

Structure
REQ-030 SHALL declare the FSM state typedef, NCH=4, and SETTLE bounds in shared package mux_scan_pkg.
REQ-031 SHALL place the FSM and settle counter in sub-module scan_sequencer, with frame capture and handshake in the top module.

Verification
REQ-032 SHALL cover: mux inputs u=01, v=00, w=11, x=10, start pulse, frame_ready=1 -> frame_data=8'hB1 after 12 cycles, s sequence 0,1,2,3, frame_par=0.
REQ-033 SHALL cover: inputs u=00, v=01, w=00, x=00 -> frame_data=8'h04, frame_par=1.
REQ-034 SHALL cover: frame_ready=0 for 20 cycles in HOLD -> frame_valid stays 1, frame_data unchanged, s=3, start pulses ignored.
REQ-035 SHALL cover: cont=1 with frame_ready=1 -> back-to-back frames every 13 cycles (12 scan + 1 HOLD), busy never drops.
REQ-036 SHALL cover: resetn low during SETTLE of channel 2 -> all outputs 0 immediately; a fresh start then yields a full correct frame.
REQ-037 SHALL cover: SETTLE=1 and SETTLE=15 -> frame_valid latency of 8 and 64 cycles respectively.
